// File: rtl/gate_level_bist.sv
// gate_level_bist: self-test sequencer for the two-input gate_level block.
// Drives {a,b} through 00, 01, 10, 11. Each vector is held for HOLD_CYCLES cycles.
// The seven gate outputs are sampled at the end of each hold and compared with the
// truth table. Results are accumulated into a saturating error count and sticky
// per-vector and per-gate masks.
// Optional feature: define GATE_BIST_INJECT_EN to add the inject_err input. That
// input inverts the expected xor bit at sample edges so the checker can test itself.
module gate_level_bist #(
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef GATE_BIST_INJECT_EN
   input  logic             inject_err,
`endif
   input  logic             and_out,
   input  logic             or_out,
   input  logic             nand_out,
   input  logic             nor_out,
   input  logic             notb_out,
   input  logic             xor_out,
   input  logic             xnor_out,
   output logic             a,
   output logic             b,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [3:0]       fail_vec,
   output logic [6:0]       fail_gates
);

   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int SUM_W  = CNT_W + 3;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic                w_accept;
   logic                w_sample;
   logic                w_last;

   logic [1:0]          r_idx;
   logic [HOLD_W-1:0]   r_hold;
   logic                r_a;
   logic                r_b;
   logic                r_busy;
   logic                r_done;
   logic                r_pass;
   logic [CNT_W-1:0]    r_err;
   logic [3:0]          r_fail_vec;
   logic [6:0]          r_fail_gates;

   logic [6:0]          w_actual;
   logic [6:0]          w_expect;
   logic [6:0]          w_mismatch;
   logic [2:0]          w_pop;
   logic [SUM_W-1:0]    w_err_sum;
   logic [CNT_W-1:0]    w_err_sat;

   // State register.
   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and control strobes: start is only honoured outside RUN.
   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_sample     = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (r_hold == HOLD_LAST) begin
               w_sample = 1'b1;
               if (r_idx == 2'd3) begin
                  w_last       = 1'b1;
                  w_state_next = S_DONE;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Compare the gate outputs against the truth table for the vector being driven.
   always_comb begin
      w_actual = {xnor_out, xor_out, notb_out, nor_out, nand_out, or_out, and_out};
      w_expect = {~(r_a ^ r_b), r_a ^ r_b, ~r_b, ~(r_a | r_b), ~(r_a & r_b),
                  r_a | r_b, r_a & r_b};
`ifdef GATE_BIST_INJECT_EN
      w_expect[5] = w_expect[5] ^ inject_err;
`endif
      w_mismatch = w_actual ^ w_expect;
      w_pop = 3'd0;
      for (int i = 0; i < 7; i++) begin
         w_pop = w_pop + {2'b00, w_mismatch[i]};
      end
      w_err_sum = SUM_W'(r_err) + SUM_W'(w_pop);
      w_err_sat = (w_err_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_err_sum[CNT_W-1:0];
   end

   // Datapath: stimulus sequencing, hold counter and result accumulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx        <= 2'd0;
         r_hold       <= '0;
         r_a          <= 1'b0;
         r_b          <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_err        <= '0;
         r_fail_vec   <= 4'd0;
         r_fail_gates <= 7'd0;
      end else if (w_accept) begin
         r_idx        <= 2'd0;
         r_hold       <= '0;
         r_a          <= 1'b0;
         r_b          <= 1'b0;
         r_busy       <= 1'b1;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_err        <= '0;
         r_fail_vec   <= 4'd0;
         r_fail_gates <= 7'd0;
      end else if (r_state == S_RUN) begin
         if (w_sample) begin
            r_hold              <= '0;
            r_err               <= w_err_sat;
            r_fail_gates        <= r_fail_gates | w_mismatch;
            r_fail_vec[r_idx]   <= r_fail_vec[r_idx] | (|w_mismatch);
            if (w_last) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
               r_pass <= (w_err_sat == '0);
               r_a    <= 1'b0;
               r_b    <= 1'b0;
            end else begin
               r_idx      <= r_idx + 2'd1;
               {r_a, r_b} <= r_idx + 2'd1;
            end
         end else begin
            r_hold <= r_hold + HOLD_W'(1);
         end
      end
   end

   assign a          = r_a;
   assign b          = r_b;
   assign busy       = r_busy;
   assign done       = r_done;
   assign pass       = r_pass;
   assign err_count  = r_err;
   assign fail_vec   = r_fail_vec;
   assign fail_gates = r_fail_gates;

endmodule
